// File: rtl/speicher_arbiter_if.sv
// speicher_arbiter_if: CPU fetch/data request ports and RAM handshake seen by speicher_arbiter.
interface speicher_arbiter_if #(
    parameter int WORTBREITE   = 32,
    parameter int ADRESSBREITE = 8
);
    logic                    LeseInstruktion;
    logic [31:0]             InstruktionAdresse;
    logic [WORTBREITE-1:0]   Instruktion;
    logic                    InstruktionGeladen;
    logic                    LeseDaten;
    logic                    SchreibeDaten;
    logic [31:0]             DatenAdresse;
    logic [WORTBREITE-1:0]   DatenRaus;
    logic [WORTBREITE-1:0]   DatenRein;
    logic                    DatenGeladen;
    logic                    DatenGespeichert;
    logic                    RAMLesenAn;
    logic                    RAMSchreibenAn;
    logic [ADRESSBREITE-1:0] RAMAdresse;
    logic [WORTBREITE-1:0]   RAMDatenRein;
    logic [WORTBREITE-1:0]   RAMDatenRaus;
    logic                    RAMDatenBereit;
    logic                    RAMDatenGeschrieben;
    logic                    Fehler;

    modport slave (
        input  LeseInstruktion, InstruktionAdresse, LeseDaten, SchreibeDaten, DatenAdresse, DatenRaus,
        input  RAMDatenRaus, RAMDatenBereit, RAMDatenGeschrieben,
        output Instruktion, InstruktionGeladen, DatenRein, DatenGeladen, DatenGespeichert,
        output RAMLesenAn, RAMSchreibenAn, RAMAdresse, RAMDatenRein, Fehler
    );

    modport master (
        output LeseInstruktion, InstruktionAdresse, LeseDaten, SchreibeDaten, DatenAdresse, DatenRaus,
        output RAMDatenRaus, RAMDatenBereit, RAMDatenGeschrieben,
        input  Instruktion, InstruktionGeladen, DatenRein, DatenGeladen, DatenGespeichert,
        input  RAMLesenAn, RAMSchreibenAn, RAMAdresse, RAMDatenRein, Fehler
    );
endinterface

// File: rtl/speicher_arbiter.sv
// speicher_arbiter: shares one single-port RAM between CPU fetch and data ports with a timeout watchdog.
// Define SPEICHER_ARBITER_FAIR_EN for round-robin instead of fixed data-over-instruction priority.
module speicher_arbiter #(
    parameter int WORTBREITE   = 32,
    parameter int ADRESSBREITE = 8,
    parameter int TIMEOUT      = 15
) (
    input logic               i_clk,
    input logic               i_rst_n,
    speicher_arbiter_if.slave bus
);
    typedef enum logic [2:0] {LEERLAUF, INSTR, LESEN, SCHREIBEN, ERHOLUNG} state_t;

    state_t                  r_state;
    logic [7:0]              r_cnt;
    logic [WORTBREITE-1:0]   r_instr, r_drein, r_wdat;
    logic [ADRESSBREITE-1:0] r_adr;
    logic                    r_igel, r_dgel, r_dges, r_rd_en, r_wr_en, r_fehler;
    logic                    w_dreq, w_ireq, w_gdata, w_timeout, w_ack, w_unused;

    assign w_dreq    = bus.LeseDaten | bus.SchreibeDaten;
    assign w_ireq    = bus.LeseInstruktion;
`ifdef SPEICHER_ARBITER_FAIR_EN
    logic r_last_data;
    assign w_gdata   = w_dreq & ~(w_ireq & r_last_data);
`else
    assign w_gdata   = w_dreq;
`endif
    // counter holds k-1 on the k-th edge after grant, so this fires on edge TIMEOUT
    assign w_timeout = r_cnt == 8'(TIMEOUT - 1);
    assign w_ack     = r_state == SCHREIBEN ? bus.RAMDatenGeschrieben : bus.RAMDatenBereit;
    assign w_unused  = ^{bus.InstruktionAdresse[31:ADRESSBREITE], bus.DatenAdresse[31:ADRESSBREITE]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= LEERLAUF;
            r_cnt    <= '0;
            r_instr  <= '0;
            r_drein  <= '0;
            r_wdat   <= '0;
            r_adr    <= '0;
            r_igel   <= 1'b0;
            r_dgel   <= 1'b0;
            r_dges   <= 1'b0;
            r_rd_en  <= 1'b0;
            r_wr_en  <= 1'b0;
            r_fehler <= 1'b0;
`ifdef SPEICHER_ARBITER_FAIR_EN
            r_last_data <= 1'b1;
`endif
        end else begin
            r_igel <= 1'b0;
            r_dgel <= 1'b0;
            r_dges <= 1'b0;
            case (r_state)
                LEERLAUF: if (w_dreq | w_ireq) begin
                    r_adr   <= w_gdata ? bus.DatenAdresse[ADRESSBREITE-1:0] : bus.InstruktionAdresse[ADRESSBREITE-1:0];
                    r_wdat  <= bus.DatenRaus;
                    r_cnt   <= '0;
                    r_wr_en <= w_gdata & bus.SchreibeDaten;
                    r_rd_en <= ~(w_gdata & bus.SchreibeDaten);
                    r_state <= !w_gdata ? INSTR : bus.SchreibeDaten ? SCHREIBEN : LESEN;
`ifdef SPEICHER_ARBITER_FAIR_EN
                    r_last_data <= w_gdata;
`endif
                end
                INSTR, LESEN, SCHREIBEN: begin
                    r_cnt <= r_cnt + 8'd1;
                    // an acknowledge on the deadline edge still counts as success
                    if (w_ack | w_timeout) begin
                        r_rd_en  <= 1'b0;
                        r_wr_en  <= 1'b0;
                        r_fehler <= r_fehler | ~w_ack;
                        r_state  <= ERHOLUNG;
                        r_igel   <= r_state == INSTR;
                        r_dgel   <= r_state == LESEN;
                        r_dges   <= r_state == SCHREIBEN;
                        if (r_state == INSTR)
                            r_instr <= w_ack ? bus.RAMDatenRaus : '0;
                        if (r_state == LESEN)
                            r_drein <= w_ack ? bus.RAMDatenRaus : '0;
                    end
                end
                ERHOLUNG: r_state <= LEERLAUF;
                default:  r_state <= LEERLAUF;
            endcase
        end
    end

    assign bus.Instruktion        = r_instr;
    assign bus.InstruktionGeladen = r_igel;
    assign bus.DatenRein          = r_drein;
    assign bus.DatenGeladen       = r_dgel;
    assign bus.DatenGespeichert   = r_dges;
    assign bus.RAMLesenAn         = r_rd_en;
    assign bus.RAMSchreibenAn     = r_wr_en;
    assign bus.RAMAdresse         = r_adr;
    assign bus.RAMDatenRein       = r_wdat;
    assign bus.Fehler             = r_fehler;
endmodule
